latent_link_rx: RTL

LATENT_LINK_RX -- requirements
Module: latent_link_rx

---
 rtl/logicnet_link_pkg.sv | 24 ++
 rtl/latent_par_chk.sv | 14 +
 rtl/latent_link_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/logicnet_link_pkg.sv
// Shared types, default constants and helpers for the latent link receiver.
package logicnet_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } link_state_t;

   localparam int unsigned DEF_CODE_W = 2;
   localparam int unsigned DEF_LINK_W = 8;
   localparam int unsigned ERR_CNT_W  = 8;

   function automatic int unsigned calc_beats(input int unsigned n_codes,
                                              input int unsigned code_w,
                                              input int unsigned link_w);
      return (n_codes * code_w) / link_w;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/latent_par_chk.sv
// Combinational even-parity check of one link beat against its parity bit.
module latent_par_chk
   import logicnet_link_pkg::*;
#(
   parameter int unsigned LINK_W = DEF_LINK_W
) (
   input  logic [LINK_W-1:0] i_data,
   input  logic              i_par,
   output logic              o_par_err_c
);

   assign o_par_err_c = (^i_data) != i_par;

endmodule

// File: rtl/latent_link_rx.sv
// Reassembles serial link beats into one parallel latent-code vector.
// Optional beat parity checking is enabled by defining LATENT_LINK_PARITY_EN.
module latent_link_rx
   import logicnet_link_pkg::*;
#(
   parameter int unsigned N_CODES = 16,
   parameter int unsigned CODE_W  = DEF_CODE_W,
   parameter int unsigned LINK_W  = DEF_LINK_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   input  logic                      s_sof,
   input  logic [LINK_W-1:0]         s_data,
`ifdef LATENT_LINK_PARITY_EN
   input  logic                      s_par,
`endif
   output logic                      s_ready,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [N_CODES*CODE_W-1:0] m_data,
   output logic                      err_sof,
   output logic [ERR_CNT_W-1:0]      err_cnt
);

   localparam int unsigned DATA_W = N_CODES * CODE_W;
   localparam int unsigned BEATS  = calc_beats(N_CODES, CODE_W, LINK_W);
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   generate
      if ((DATA_W % LINK_W) != 0 || BEATS == 0) begin : g_bad_cfg
         $error("latent_link_rx: N_CODES*CODE_W must be a nonzero multiple of LINK_W");
      end
   endgenerate

   link_state_t          r_state;
   logic [CNT_W-1:0]     r_beat_cnt;
   logic [DATA_W-1:0]    r_data;
   logic                 r_m_valid;
   logic                 r_s_ready;
   logic                 r_err_sof;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic                 r_bad;

   logic w_accept;
   logic w_par_err;
   logic w_err;

`ifdef LATENT_LINK_PARITY_EN
   latent_par_chk #(.LINK_W(LINK_W)) u_par_chk (
      .i_data      (s_data),
      .i_par       (s_par),
      .o_par_err_c (w_par_err)
   );
`else
   assign w_par_err = 1'b0;
`endif

   assign w_accept = s_valid && r_s_ready;
   // A new sof while a frame is being collected is a framing error.
   assign w_err    = w_accept && (w_par_err || (r_state == ST_COLLECT && s_sof));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
         r_data     <= '0;
         r_m_valid  <= 1'b0;
         r_s_ready  <= 1'b1;
         r_err_sof  <= 1'b0;
         r_err_cnt  <= '0;
         r_bad      <= 1'b0;
      end else begin
         r_err_sof <= w_err;
         if (w_err) r_err_cnt <= sat_inc(r_err_cnt);

         case (r_state)
            ST_IDLE: begin
               if (w_accept && s_sof) begin
                  r_data[LINK_W-1:0] <= s_data;
                  r_beat_cnt         <= CNT_W'(1);
                  r_bad              <= w_par_err;
                  if (BEATS == 1) begin
                     if (!w_par_err) begin
                        r_state   <= ST_HOLD;
                        r_m_valid <= 1'b1;
                        r_s_ready <= 1'b0;
                     end
                  end else begin
                     r_state <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (w_accept) begin
                  if (s_sof) begin
                     r_data[LINK_W-1:0] <= s_data;
                     r_beat_cnt         <= CNT_W'(1);
                     r_bad              <= w_par_err;
                  end else begin
                     r_data[r_beat_cnt*LINK_W +: LINK_W] <= s_data;
                     if (r_beat_cnt == CNT_W'(BEATS - 1)) begin
                        r_beat_cnt <= '0;
                        r_bad      <= 1'b0;
                        // A frame that saw a parity error is dropped silently.
                        if (r_bad || w_par_err) begin
                           r_state <= ST_IDLE;
                        end else begin
                           r_state   <= ST_HOLD;
                           r_m_valid <= 1'b1;
                           r_s_ready <= 1'b0;
                        end
                     end else begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        r_bad      <= r_bad || w_par_err;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (r_m_valid && m_ready) begin
                  r_state    <= ST_IDLE;
                  r_m_valid  <= 1'b0;
                  r_s_ready  <= 1'b1;
                  r_beat_cnt <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_ready = r_s_ready;
   assign m_valid = r_m_valid;
   assign m_data  = r_data;
   assign err_sof = r_err_sof;
   assign err_cnt = r_err_cnt;

endmodule
